// File: rtl/bus_arbiter_router.sv
// bus_arbiter_router: round-robin arbiter over terminal input FIFOs, routing each packet by ID to output FIFOs
// clk, reset (sync, active-low); pndng/D_pop in from input FIFOs, pop strobes back to them;
// push/D_push out to output FIFOs; busy while a packet is in flight; drop pulses on an invalid ID.
module bus_arbiter_router #(
  parameter int width = 16,
  parameter int drivers = 4,
  parameter logic [7:0] bcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drivers-1:0]         pndng,
  input  logic [drivers*width-1:0]   D_pop,
  output logic [drivers-1:0]         pop,
  output logic [drivers-1:0]         push,
  output logic [drivers*width-1:0]   D_push,
  output logic                       busy,
  output logic                       drop
);
  localparam int pw = $clog2(drivers);
  typedef enum logic [1:0] {IDLE, GRANT, SEND} state_t;
  state_t state_q;
  logic [pw-1:0] rr_q, src_q, win;
  logic [width-1:0] pkt_q;
  logic [drivers-1:0] pop_q, push_q, win_oh, dst_oh;
  logic [drivers*width-1:0] d_push_q;
  logic busy_q, drop_q, uni, bc;
  logic [7:0] id;
  int j;
  // Scan from rr_q downward in priority so the lowest rotated offset wins.
  always_comb begin
    id = pkt_q[width-1 -: 8];
    uni = int'(id) < drivers;
    bc = id == bcast;
    win = rr_q;
    j = 0;
    for (int i = drivers - 1; i >= 0; i--) begin
      j = int'(rr_q) + i;
      if (j >= drivers) j = j - drivers;
      if (pndng[j]) win = pw'(j);
    end
    win_oh = drivers'(1) << win;
    dst_oh = bc ? ~(drivers'(1) << src_q) : drivers'(1) << id;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q <= '0;
      src_q <= '0;
      pkt_q <= '0;
      pop_q <= '0;
      push_q <= '0;
      d_push_q <= '0;
      busy_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      pop_q <= '0;
      push_q <= '0;
      d_push_q <= '0;
      drop_q <= 1'b0;
      case (state_q)
        IDLE: if (|pndng) begin
          pkt_q <= D_pop[win*width +: width];
          src_q <= win;
          pop_q <= win_oh;
          busy_q <= 1'b1;
          state_q <= GRANT;
        end
        GRANT: begin
          rr_q <= (src_q == pw'(drivers - 1)) ? '0 : src_q + 1'b1;
          if (uni || bc) state_q <= SEND;
          else begin
            drop_q <= 1'b1;
            busy_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        SEND: begin
          push_q <= dst_oh;
          d_push_q <= {drivers{pkt_q}};
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign pop = pop_q;
  assign push = push_q;
  assign D_push = d_push_q;
  assign busy = busy_q;
  assign drop = drop_q;
endmodule

// File: tb/tb_bus_arbiter_router.sv
// tb_bus_arbiter_router: scoreboard-driven bench for bus_arbiter_router
module tb_bus_arbiter_router;
  logic clk, reset;
  logic [3:0] pndng, pop, push;
  logic [63:0] D_pop, D_push;
  logic busy, drop;
  int checks = 0;
  int passed = 0;
  typedef struct packed {logic [3:0] mask; logic [15:0] data;} exp_t;
  exp_t sb[$];

  bus_arbiter_router #(.width(16), .drivers(4), .bcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push), .busy(busy), .drop(drop)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    if (push !== 4'b0) begin
      checks++;
      if (sb.size() == 0) $display("FAIL sb_unexpected_push got=%b required=none", push);
      else begin
        e = sb.pop_front();
        if (push !== e.mask) $display("FAIL sb_push_mask got=%b required=%b", push, e.mask);
        else passed++;
        for (int i = 0; i < 4; i++) if (e.mask[i]) begin
          checks++;
          if (D_push[i*16 +: 16] !== e.data) $display("FAIL sb_data lane%0d got=%h required=%h", i, D_push[i*16 +: 16], e.data);
          else passed++;
        end
      end
    end
  end

  task automatic wait_pop(output logic found);
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk); #1;
      if (pop !== 4'b0) found = 1;
    end
    if (!found) begin
      checks++;
      $display("FAIL pop_timeout got=none required=pop");
    end
  endtask

  task automatic test_reset;
    reset = 0; pndng = 4'hF; D_pop = 64'h0001_0102_0203_0300;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks += 4;
      if (pop !== 4'b0) $display("FAIL reset_pop got=%b required=0000", pop); else passed++;
      if (push !== 4'b0) $display("FAIL reset_push got=%b required=0000", push); else passed++;
      if (D_push !== 64'b0) $display("FAIL reset_dpush got=%h required=0", D_push); else passed++;
      if (busy !== 1'b0) $display("FAIL reset_busy got=%b required=0", busy); else passed++;
    end
    pndng = 0;
    reset = 1;
  endtask

  task automatic test_unicast;
    logic f;
    D_pop[16 +: 16] = 16'h02A5;
    pndng = 4'b0010;
    sb.push_back('{4'b0100, 16'h02A5});
    wait_pop(f);
    if (f) begin
      checks += 2;
      if (pop !== 4'b0010) $display("FAIL uni_pop got=%b required=0010", pop); else passed++;
      if (busy !== 1'b1) $display("FAIL uni_busy got=%b required=1", busy); else passed++;
      pndng = 0;
      @(posedge clk); #1;
      checks++;
      if (pop !== 4'b0) $display("FAIL uni_pop_clear got=%b required=0000", pop); else passed++;
      @(posedge clk); #1;
      checks += 3;
      if (push !== 4'b0100) $display("FAIL uni_push got=%b required=0100", push); else passed++;
      if (D_push[32 +: 16] !== 16'h02A5) $display("FAIL uni_data got=%h required=02a5", D_push[32 +: 16]); else passed++;
      if (busy !== 1'b0) $display("FAIL uni_busy_done got=%b required=0", busy); else passed++;
      @(posedge clk); #1;
      checks++;
      if (push !== 4'b0) $display("FAIL uni_push_clear got=%b required=0000", push); else passed++;
    end
    pndng = 0;
  endtask

  task automatic test_round_robin;
    int order[5] = '{0, 1, 2, 3, 0};
    int cyc[5];
    logic [3:0] got[5];
    int n = 0;
    reset = 0; @(posedge clk); #1; reset = 1;
    for (int i = 0; i < 4; i++) D_pop[i*16 +: 16] = {8'((i + 1) % 4), 8'(8'hA0 + i)};
    for (int k = 0; k < 5; k++) sb.push_back('{4'(1 << ((order[k] + 1) % 4)), {8'((order[k] + 1) % 4), 8'(8'hA0 + order[k])}});
    pndng = 4'hF;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(posedge clk); #1;
      if (pop !== 4'b0) begin
        got[n] = pop; cyc[n] = c; n++;
        if (n == 5) pndng = 0;
      end
    end
    pndng = 0;
    checks++;
    if (n != 5) $display("FAIL rr_grant_count got=%0d required=5", n); else passed++;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got[k] !== 4'(1 << order[k])) $display("FAIL rr_grant%0d got=%b required=%b", k, got[k], 4'(1 << order[k])); else passed++;
      if (k > 0) begin
        checks++;
        if (cyc[k] - cyc[k-1] != 3) $display("FAIL rr_spacing%0d got=%0d required=3", k, cyc[k] - cyc[k-1]); else passed++;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_broadcast;
    logic f;
    int c;
    D_pop[48 +: 16] = 16'hFF11;
    pndng = 4'b1000;
    sb.push_back('{4'b0111, 16'hFF11});
    wait_pop(f);
    pndng = 0;
    if (f) begin
      checks++;
      if (pop !== 4'b1000) $display("FAIL bc_pop got=%b required=1000", pop); else passed++;
      for (c = 0; c < 5 && push === 4'b0; c++) begin @(posedge clk); #1; end
      checks += 4;
      if (push !== 4'b0111) $display("FAIL bc_push got=%b required=0111", push); else passed++;
      for (int i = 0; i < 3; i++)
        if (D_push[i*16 +: 16] !== 16'hFF11) $display("FAIL bc_data lane%0d got=%h required=ff11", i, D_push[i*16 +: 16]); else passed++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_drop;
    logic f;
    D_pop[0 +: 16] = 16'h0733;
    pndng = 4'b0001;
    wait_pop(f);
    pndng = 0;
    if (f) begin
      checks++;
      if (pop !== 4'b0001) $display("FAIL drop_pop got=%b required=0001", pop); else passed++;
      @(posedge clk); #1;
      checks += 2;
      if (drop !== 1'b1) $display("FAIL drop_pulse got=%b required=1", drop); else passed++;
      if (push !== 4'b0) $display("FAIL drop_push got=%b required=0000", push); else passed++;
      @(posedge clk); #1;
      checks += 2;
      if (drop !== 1'b0) $display("FAIL drop_clear got=%b required=0", drop); else passed++;
      if (push !== 4'b0) $display("FAIL drop_push2 got=%b required=0000", push); else passed++;
    end
  endtask

  task automatic test_reset_mid;
    logic f;
    D_pop[32 +: 16] = 16'h01C3;
    pndng = 4'b0100;
    wait_pop(f);
    pndng = 0;
    if (f) begin
      reset = 0;
      @(posedge clk); #1;
      checks += 2;
      if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%b required=0", busy); else passed++;
      if (push !== 4'b0) $display("FAIL rst_mid_push got=%b required=0000", push); else passed++;
      reset = 1;
      repeat (3) begin
        @(posedge clk); #1;
        checks++;
        if (push !== 4'b0) $display("FAIL rst_mid_nopush got=%b required=0000", push); else passed++;
      end
      for (int i = 0; i < 4; i++) D_pop[i*16 +: 16] = {8'(3 - i), 8'(8'h50 + i)};
      sb.push_back('{4'b1000, 16'h0350});
      pndng = 4'hF;
      wait_pop(f);
      pndng = 0;
      if (f) begin
        checks++;
        if (pop !== 4'b0001) $display("FAIL rst_mid_restart got=%b required=0001", pop); else passed++;
      end
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 0; pndng = 0; D_pop = 0;
    test_reset;
    test_unicast;
    test_round_robin;
    test_broadcast;
    test_drop;
    test_reset_mid;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) $display("FAIL sb_leftover got=%0d required=0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
